mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, byte-address width.
REQ-002 Parameter DATA_W, default 64, data word width.
REQ-003 Parameter MEM_BYTES, default 524288, size of addressable RAM in bytes.
REQ-004 clk  input  1  clock; all state changes on posedge clk.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  2  per-requester access request; index 0 = core data port, index 1 = loader/debug port.
REQ-007 req_ready  output  2  one-hot grant/accept; handshake when req_valid[i] and req_ready[i] are both high.
REQ-008 req_write  input  2  per-requester write (1) or read (0).
REQ-009 req_addr  input  2xADDR_W  per-requester byte address.
REQ-010 req_wdata  input  2xDATA_W  per-requester write data.
REQ-011 rsp_valid  output  2  one-cycle response strobe to the granted requester.
REQ-012 rsp_rdata  output  DATA_W  read data, valid with rsp_valid; zero for writes and errors.
REQ-013 rsp_error  output  1  access fault, valid with rsp_valid.
REQ-014 mem_addr  output  ADDR_W  address to the RAM read/write port.
REQ-015 mem_wdata  output  DATA_W  write data to the RAM.
REQ-016 mem_write_en  output  1  RAM write strobe.
REQ-017 mem_rdata  input  DATA_W  RAM read data, registered, valid one cycle after mem_addr.
REQ-018 mem_error  input  1  RAM fault flag, same timing as mem_rdata.

Function
REQ-019 FSM states IDLE, ISSUE, RESP; at most one transaction in flight.
REQ-020 IDLE: req_ready asserted combinationally for the winning valid requester only; no grant when neither valid.
REQ-021 Arbitration round-robin: if both valid, grant the index not granted last; single valid requester always wins.
REQ-022 On handshake in IDLE: latch index, write, addr, wdata; run checks; go to ISSUE if checks pass, else RESP with fault.
REQ-023 Checks: addr[2:0] nonzero = misaligned fault; addr + 8 > MEM_BYTES = range fault; both evaluated on full ADDR_W without wrap.
REQ-024 ISSUE (one cycle): drive mem_addr/mem_wdata from latch; mem_write_en = latched write; go to RESP.
REQ-025 RESP (one cycle): rsp_valid[latched index] = 1; rsp_rdata = mem_rdata for reads else 0; rsp_error = fault OR mem_error; go to IDLE.
REQ-026 Latency: handshake at cycle N, mem_write_en/mem_addr at N+1, rsp_valid at N+2; faulted request rsp_valid at N+1, no mem_write_en.
REQ-027 req_ready deasserted in ISSUE and RESP; next grant no earlier than the cycle after RESP.
REQ-028 mem_write_en high only in ISSUE of a non-faulted write; zero in every other cycle.
REQ-029 Outside ISSUE, mem_addr/mem_wdata hold last value; mem_rdata/mem_error ignored outside RESP.
REQ-030 req_valid dropped without handshake: no state change, round-robin pointer unchanged.

Reset
REQ-031 On reset: state IDLE, req_ready 0 during reset cycle, rsp_valid 0, rsp_rdata 0, rsp_error 0, mem_addr 0, mem_wdata 0, mem_write_en 0.
REQ-032 Round-robin pointer reset to "last granted = 1", so requester 0 wins the first contention.
REQ-033 Reset in ISSUE or RESP aborts the transaction: no rsp_valid, mem_write_en 0 from the next cycle.

Structure
REQ-034 Shared package holds FSM state enum, requester index constants (REQ_CORE=0, REQ_LOADER=1), default MEM_BYTES.
REQ-035 Single flat module; the round-robin pick is one combinational function, no sub-module.

Verification
REQ-036 Core read addr 0x10 only, RAM returns 0xDEADBEEF -> req_ready[0] at N, mem_addr 0x10 at N+1, rsp_valid[0] with rdata 0xDEADBEEF, error 0 at N+2.
REQ-037 Both valid at once for 4 back-to-back transactions -> grants alternate 0,1,0,1; each response on the matching index.
REQ-038 Loader write addr 0x7FFF8 data 0x55 -> mem_write_en single cycle at N+1; write addr 0x80000 -> rsp_error 1 at N+1, mem_write_en never high.
REQ-039 Core read addr 0x13 -> rsp_error 1, rsp_rdata 0, no RAM access; mem_error=1 on a legal read -> rsp_error 1.
REQ-040 Reset asserted in ISSUE of a write -> no rsp_valid, mem_write_en 0 after reset, next contention grants index 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arbiter_pkg;

  localparam int          NUM_REQ       = 2;
  localparam logic        REQ_CORE      = 1'b0;
  localparam logic        REQ_LOADER    = 1'b1;
  localparam int unsigned DEF_MEM_BYTES = 524288;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Per-transaction bookkeeping carried from grant to response.
  typedef struct packed {
    logic idx;
    logic write;
    logic fault;
  } txn_meta_t;

  // Round-robin pick: a lone requester always wins; on contention the
  // requester that was not granted last time wins.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic               last_idx);
    logic [NUM_REQ-1:0] g;
    g = valid;
    if (&valid) g = (last_idx == REQ_LOADER) ? 2'b01 : 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signal bundle; the arbiter sits on the slave modport.
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  import mem_arbiter_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;

  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_rdata;
  logic                           rsp_error;

  logic [ADDR_W-1:0]              mem_addr;
  logic [DATA_W-1:0]              mem_wdata;
  logic                           mem_write_en;
  logic [DATA_W-1:0]              mem_rdata;
  logic                           mem_error;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_error,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, mem_addr, mem_wdata, mem_write_en
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_error,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, mem_addr, mem_wdata, mem_write_en
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with a
// registered read; one transaction in flight, alignment/range checked.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int          ADDR_W    = 64,
  parameter int          DATA_W    = 64,
  parameter int unsigned MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  state_e             state_q, state_d;
  logic               last_q, last_d;
  txn_meta_t          meta_q, meta_d;
  logic [ADDR_W-1:0]  maddr_q, maddr_d;
  logic [DATA_W-1:0]  mwdata_q, mwdata_d;

  logic [NUM_REQ-1:0] grant;
  logic               hs;
  logic               sel;
  logic [ADDR_W-1:0]  sel_addr;
  logic [ADDR_W:0]    end_addr;
  logic               misalign;
  logic               out_of_range;
  logic               fault;

  // Grant and access checks for the requester being accepted this cycle.
  always_comb begin
    grant        = '0;
    if (state_q == ST_IDLE && !reset) grant = rr_pick(bus.req_valid, last_q);
    hs           = |grant;
    sel          = grant[1];
    sel_addr     = bus.req_addr[sel];
    // One extra bit so addresses near the top of ADDR_W cannot wrap into range.
    end_addr     = {1'b0, sel_addr} + (ADDR_W+1)'(8);
    misalign     = |sel_addr[2:0];
    out_of_range = end_addr > (ADDR_W+1)'(MEM_BYTES);
    fault        = misalign | out_of_range;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (hs) state_d = fault ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Latch the accepted request; the RAM address/data only move for legal
  // accesses so they hold their previous value across faults and idle time.
  always_comb begin
    last_d   = last_q;
    meta_d   = meta_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    if (hs) begin
      last_d       = sel;
      meta_d.idx   = sel;
      meta_d.write = bus.req_write[sel];
      meta_d.fault = fault;
      if (!fault) begin
        maddr_d  = sel_addr;
        mwdata_d = bus.req_wdata[sel];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= REQ_LOADER;
      meta_q   <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      last_q   <= last_d;
      meta_q   <= meta_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  // Outputs are forced quiet while reset is held so an aborted ISSUE never strobes.
  always_comb begin
    bus.req_ready    = grant;
    bus.mem_addr     = reset ? '0 : maddr_q;
    bus.mem_wdata    = reset ? '0 : mwdata_q;
    bus.mem_write_en = 1'b0;
    bus.rsp_valid    = '0;
    bus.rsp_rdata    = '0;
    bus.rsp_error    = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_ISSUE: bus.mem_write_en = meta_q.write;
        ST_RESP: begin
          bus.rsp_valid[meta_q.idx] = 1'b1;
          bus.rsp_error             = meta_q.fault | bus.mem_error;
          if (!meta_q.write && !bus.rsp_error) bus.rsp_rdata = bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference
// model (grant order, fault rules, latency, memory contents).
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int              AW   = 64;
  localparam int              DW   = 64;
  localparam longint unsigned MEMB = 524288;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_BYTES(524288)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] ram     [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];
  logic        err_inj = 1'b0;
  logic        rr_last;

  function automatic logic [63:0] init_word(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
  endfunction

  // RAM model: registered read, write on strobe, injected fault with read timing.
  always @(posedge clk) begin
    bus.mem_rdata <= ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : init_word(bus.mem_addr);
    bus.mem_error <= err_inj;
    if (bus.mem_write_en) ram[bus.mem_addr] = bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit exp_fault(input logic [63:0] a);
    return (a % 8 != 0) || (a > MEMB - 8);
  endfunction

  function automatic int model_pick(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    if (v == 2'b11) return rr_last ? 0 : 1;
    return -1;
  endfunction

  task automatic txn(input logic [1:0] v, input logic [1:0] wr,
                     input logic [1:0][63:0] a, input logic [1:0][63:0] d,
                     input bit inj, input string tag);
    int          g;
    bit          f;
    logic [1:0]  oh;
    logic [63:0] exp_rd;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    #1;
    g = model_pick(v);
    chk({tag, "/n_wen"}, bus.mem_write_en, 0);
    chk({tag, "/n_rsp"}, bus.rsp_valid, 0);
    if (g < 0) begin
      chk({tag, "/idle_ready"}, bus.req_ready, 0);
      return;
    end
    oh = 2'b01 << g;
    chk({tag, "/ready"}, bus.req_ready, oh);
    rr_last = g[0];
    f = exp_fault(a[g]);
    @(negedge clk); #1;
    chk({tag, "/n1_ready"}, bus.req_ready, 0);
    if (f) begin
      chk({tag, "/f_rsp"}, bus.rsp_valid, oh);
      chk({tag, "/f_err"}, bus.rsp_error, 1);
      chk({tag, "/f_rdata"}, bus.rsp_rdata, 0);
      chk({tag, "/f_wen"}, bus.mem_write_en, 0);
    end else begin
      chk({tag, "/n1_rsp"}, bus.rsp_valid, 0);
      chk({tag, "/wen"}, bus.mem_write_en, wr[g]);
      chk({tag, "/maddr"}, bus.mem_addr, a[g]);
      if (wr[g]) chk({tag, "/mwdata"}, bus.mem_wdata, d[g]);
      err_inj = inj;
      @(negedge clk); #1;
      err_inj = 1'b0;
      exp_rd = (wr[g] || inj) ? 64'h0 :
               (ref_mem.exists(a[g]) ? ref_mem[a[g]] : init_word(a[g]));
      chk({tag, "/rsp"}, bus.rsp_valid, oh);
      chk({tag, "/err"}, bus.rsp_error, inj);
      chk({tag, "/rdata"}, bus.rsp_rdata, exp_rd);
      chk({tag, "/n2_wen"}, bus.mem_write_en, 0);
      chk({tag, "/n2_ready"}, bus.req_ready, 0);
      if (wr[g]) ref_mem[a[g]] = d[g];
    end
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return 64'($urandom_range(0, 31)) * 8;
      6:                return MEMB - 8;
      7:                return MEMB;
      8:                return {$urandom, $urandom};
      default:          return 64'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [1:0][63:0] a, d;
    bus.req_valid = 2'b11;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset state with both requesters asking.
    @(negedge clk); @(negedge clk); #1;
    chk("rst/ready", bus.req_ready, 0);
    chk("rst/rsp", bus.rsp_valid, 0);
    chk("rst/rdata", bus.rsp_rdata, 0);
    chk("rst/err", bus.rsp_error, 0);
    chk("rst/maddr", bus.mem_addr, 0);
    chk("rst/mwdata", bus.mem_wdata, 0);
    chk("rst/wen", bus.mem_write_en, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 2'b00;
    rr_last = 1'b1;

    // Four back-to-back contended transactions alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      a = {64'($urandom_range(0, 31)) * 8, 64'($urandom_range(0, 31)) * 8};
      d = {{$urandom, $urandom}, {$urandom, $urandom}};
      txn(2'b11, 2'($urandom), a, d, 1'b0, $sformatf("rr%0d", i));
    end

    // Core read of a preloaded word.
    ram[64'h10] = 64'hDEADBEEF;
    ref_mem[64'h10] = 64'hDEADBEEF;
    txn(2'b01, 2'b00, {64'h0, 64'h10}, '0, 1'b0, "core_rd");

    // Top-of-RAM boundary write, read back, and one past the end.
    txn(2'b10, 2'b10, {64'h7FFF8, 64'h0}, {64'h55, 64'h0}, 1'b0, "ld_wr_top");
    txn(2'b01, 2'b00, {64'h0, 64'h7FFF8}, '0, 1'b0, "core_rd_top");
    txn(2'b10, 2'b10, {64'h80000, 64'h0}, {64'h66, 64'h0}, 1'b0, "ld_wr_oor");
    txn(2'b01, 2'b00, {64'h0, 64'h13}, '0, 1'b0, "core_mis");
    txn(2'b01, 2'b00, {64'h0, 64'hFFFF_FFFF_FFFF_FFF8}, '0, 1'b0, "core_wrap");
    txn(2'b01, 2'b00, {64'h0, 64'h20}, '0, 1'b1, "core_memerr");
    txn(2'b00, 2'b00, '0, '0, 1'b0, "idle");

    // Reset while a write sits in ISSUE.
    @(negedge clk);
    bus.req_valid = 2'b10;
    bus.req_write = 2'b10;
    bus.req_addr  = {64'h40000, 64'h0};
    bus.req_wdata = {64'h77, 64'h0};
    #1;
    chk("rstx/ready", bus.req_ready, 2'b10);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstx/rst_ready", bus.req_ready, 0);
    chk("rstx/rst_wen", bus.mem_write_en, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    chk("rstx/rsp", bus.rsp_valid, 0);
    chk("rstx/wen", bus.mem_write_en, 0);
    chk("rstx/maddr", bus.mem_addr, 0);
    rr_last = 1'b1;
    txn(2'b11, 2'b00, {64'h8, 64'h18}, '0, 1'b0, "rstx_cont");

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      a = {rand_addr(), rand_addr()};
      d = {{$urandom, $urandom}, {$urandom, $urandom}};
      txn(2'($urandom), 2'($urandom), a, d, ($urandom_range(0, 7) == 0),
          $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
